// File: rtl/universal_shift_reg.sv
// universal_shift_reg: a register that supports parallel load and multi-step shifts.
// One start request performs 'amt' single-bit shifts, one per clock, either left
// (toward the MSB) or right (toward the LSB). The bit shifted out of the register
// is captured in sout, and done pulses for one cycle when the operation finishes.
// Optional feature: define USR_ROTATE_EN to add a 'rot' input. When rot is set,
// the bit shifted out is fed back into the vacated position instead of sin.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             dir,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic             rot_in;
  logic             exit_bit;
  logic             fill_bit;
  logic [WIDTH-1:0] shifted;

`ifdef USR_ROTATE_EN
  assign rot_in = rot;
`else
  assign rot_in = 1'b0;
`endif

  // One-position shift of the current contents using the direction and fill mode latched at start
  always_comb begin
    exit_bit = dir_q ? q_q[0] : q_q[WIDTH-1];
    fill_bit = rot_q ? exit_bit : sin;
    shifted  = dir_q ? {fill_bit, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill_bit};
  end

  // Next-state logic: requests are honoured only in IDLE, and load takes priority over start
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          q_d = d;
        end else if (start) begin
          if (amt != '0) begin
            cnt_d   = amt;
            dir_d   = dir;
            rot_d   = rot_in;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        q_d    = shifted;
        sout_d = exit_bit;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Testbench for universal_shift_reg. The stimulus process queues the expected
// result of every clock edge; a separate monitor pops and compares those entries.
module tb_universal_shift_reg;
  localparam int W  = 8;
  localparam int AW = 3;
`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  localparam int K_IDLE  = 0;
  localparam int K_LOAD  = 1;
  localparam int K_SHIFT = 2;
  localparam int K_DONE  = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          load  = 1'b0;
  logic          start = 1'b0;
  logic          dir   = 1'b0;
  logic          sin   = 1'b0;
  logic          rot   = 1'b0;
  logic [W-1:0]  d     = '0;
  logic [AW-1:0] amt   = '0;
  logic [W-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  universal_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d     (d),
    .start (start),
    .dir   (dir),
    .amt   (amt),
    .sin   (sin),
`ifdef USR_ROTATE_EN
    .rot   (rot),
`endif
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int qv;
    int sv;
    int nbusy;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    m_q    = 0;
  int    m_sout = 0;
  string knames[4] = '{"idle", "load", "shift", "done"};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int nb);
    exp_t e;
    e.kind  = kind;
    e.qv    = m_q;
    e.sv    = m_sout;
    e.nbusy = nb;
    sbq.push_back(e);
  endtask

  // Reference model: one shift written as arithmetic on an integer value
  task automatic model_shift(input int dr, input int s, input int r);
    int outb;
    int fill;
    if (dr == 0) outb = m_q / (1 << (W - 1));
    else         outb = m_q % 2;
    fill = (r != 0) ? outb : s;
    if (dr == 0) m_q = (m_q * 2) % (1 << W) + fill;
    else         m_q = m_q / 2 + fill * (1 << (W - 1));
    m_sout = outb;
  endtask

  // ---------------- monitor ----------------
  logic was_busy = 1'b0;
  logic was_idle = 1'b0;
  logic s_ld     = 1'b0;
  logic s_st     = 1'b0;
  int   busy_cnt = 0;

  task automatic expect_pop(input int kind);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL underflow: observed %s event, expected nothing", knames[kind]);
      return;
    end
    e = sbq.pop_front();
    check($sformatf("event_kind(%s)", knames[e.kind]), kind, e.kind);
    check($sformatf("%s_q", knames[e.kind]), q, e.qv);
    check($sformatf("%s_sout", knames[e.kind]), sout, e.sv);
    if (kind == K_DONE) begin
      check("busy_cycles", busy_cnt, e.nbusy);
      busy_cnt = 0;
    end
  endtask

  always @(posedge clk) begin
    was_busy = (busy === 1'b1);
    was_idle = (busy === 1'b0) && (done === 1'b0);
    s_ld     = load;
    s_st     = start;
  end

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (was_busy) begin
        expect_pop(K_SHIFT);
      end else if (was_idle) begin
        if (s_ld)       expect_pop(K_LOAD);
        else if (!s_st) expect_pop(K_IDLE);
      end
      if (done === 1'b1) expect_pop(K_DONE);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_idle();
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    d     = W'($urandom);
    dir   = 1'($urandom);
    amt   = AW'($urandom);
    sin   = 1'($urandom);
    push(K_IDLE, 0);
  endtask

  task automatic do_load(input int v, input logic st);
    @(negedge clk);
    load  = 1'b1;
    start = st;
    d     = W'(v);
    dir   = 1'($urandom);
    amt   = AW'($urandom);
    sin   = 1'($urandom);
    m_q   = v;
    push(K_LOAD, 0);
  endtask

  // sinmode 0/1 drives a fixed fill bit, 2 drives a random one every cycle
  task automatic do_start(input int dr, input int k, input int r, input int sinmode);
    int lat_r;
    lat_r = ROT_EN ? r : 0;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b1;
    dir   = 1'(dr);
    amt   = AW'(k);
    rot   = 1'(r);
    sin   = 1'($urandom);
    if (k == 0) push(K_DONE, 0);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      load  = 1'($urandom);
      start = 1'($urandom);
      d     = W'($urandom);
      dir   = 1'($urandom);
      amt   = AW'($urandom);
      rot   = 1'($urandom);
      sin   = (sinmode == 2) ? 1'($urandom) : 1'(sinmode);
      model_shift(dr, int'(sin), lat_r);
      push(K_SHIFT, 0);
      if (i == k) push(K_DONE, k);
    end
    @(negedge clk);
    load  = 1'($urandom);
    start = 1'($urandom);
    d     = W'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    #3 rst_n = 1'b0;
    #1;
    check("reset_q", q, 0);
    check("reset_sout", sout, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    m_q    = 0;
    m_sout = 0;
    push(K_IDLE, 0);

    do_load(8'hA5, 1'b0);
    do_start(0, 3, 0, 1);
    do_idle();
    if (ROT_EN) begin
      do_load(8'h81, 1'b0);
      do_start(1, 1, 1, 0);
    end
    do_load(8'h5A, 1'b0);
    do_start(1, 0, 0, 2);
    do_load(8'h3C, 1'b1);
    do_idle();
    do_idle();

    // Reset in the middle of a five-step shift
    do_load(8'h5A, 1'b0);
    @(negedge clk);
    load  = 1'b0;
    start = 1'b1;
    dir   = 1'b0;
    amt   = AW'(5);
    sin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sin   = 1'b0;
    model_shift(0, 0, 0);
    push(K_SHIFT, 0);
    @(negedge clk);
    sin = 1'b1;
    #2 rst_n = 1'b0;
    sbq.delete();
    m_q    = 0;
    m_sout = 0;
    #1;
    check("midreset_q", q, 0);
    check("midreset_sout", sout, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    load  = 1'b1;
    start = 1'b0;
    d     = 8'hFF;
    m_q   = 8'hFF;
    push(K_LOAD, 0);
    do_idle();

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      do_idle();
      else if (sel < 5) do_load($urandom_range(0, 255), 1'($urandom));
      else              do_start($urandom_range(0, 1), $urandom_range(0, 7),
                                 $urandom_range(0, 1), 2);
    end
    do_idle();
    @(negedge clk);
    #1;
    check("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (>=2) SHALL be supported.
REQ-002 Parameter AMT_W, default 3, shift-amount field width SHALL be supported.
REQ-003 clk  input  1  the block's only clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  parallel-load request.
REQ-006 d  input  WIDTH  parallel-load data.
REQ-007 start  input  1  multi-step shift request.
REQ-008 dir  input  1  direction: 0 = left (toward MSB), 1 = right (toward LSB).
REQ-009 amt  input  AMT_W  number of single-bit shifts to perform.
REQ-010 sin  input  1  serial fill bit for vacated position.
REQ-011 q  output  WIDTH  register contents.
REQ-012 sout  output  1  last bit shifted out.
REQ-013 busy  output  1  high while shifting.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM SHALL have states IDLE, SHIFT and DONE.
REQ-016 In IDLE with load=1, q SHALL take d at the next edge; the FSM SHALL stay in IDLE.
REQ-017 Priority: in IDLE with load=1 and start=1 together, load SHALL win and start SHALL be dropped.
REQ-018 In IDLE with start=1, load=0 and amt!=0, the block SHALL latch amt into a down-counter, latch dir (and rot when present), and enter SHIFT.
REQ-019 In IDLE with start=1 and amt=0, the block SHALL enter DONE directly; q and sout SHALL be unchanged and busy SHALL stay 0.
REQ-020 In SHIFT, q SHALL shift one position per cycle in the latched direction; sin, sampled each cycle, SHALL fill the vacated bit; the exiting bit SHALL be registered into sout.
REQ-021 In SHIFT, the counter SHALL decrement each cycle; the shift taken when the count equals 1 SHALL be the last one, and the FSM SHALL then enter DONE.
REQ-022 Latency: with start accepted at edge T0 and amt=k, shifts SHALL occur at edges T1..Tk, done SHALL be high for the single cycle after Tk, and the FSM SHALL return to IDLE at T(k+1).
REQ-023 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE).
REQ-024 load and start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-025 Changes to d, dir, amt (and rot) during SHIFT SHALL have no effect.
REQ-026 In IDLE with neither request asserted, q and sout SHALL hold.

Reset
REQ-027 rst_n=0 SHALL immediately force q=0, sout=0, counter=0, state IDLE, busy=0 and done=0, including in the middle of an operation.
REQ-028 After rst_n deasserts, the first request SHALL be accepted on the first rising edge.

Configuration
REQ-029 Macro USR_ROTATE_EN defined: a 1-bit input rot SHALL exist, latched at start; with rot=1, the exiting bit SHALL fill the vacated position instead of sin, and sout SHALL still capture the exiting bit.
REQ-030 Macro USR_ROTATE_EN undefined: port rot SHALL be absent and every shift SHALL use sin fill.

Verification (WIDTH=8, AMT_W=3)
REQ-031 Apply rst_n=0 -> q=8'h00, sout=0, busy=0, done=0 with no clock edge required.
REQ-032 In IDLE, load=1 with d=8'hA5 -> q=8'hA5 after one edge; busy stays 0.
REQ-033 With q=8'hA5, start with dir=0, amt=3, sin=1 -> q steps 4B, 97, 2F; busy high for 3 cycles; sout=1; done high for exactly 1 cycle after that.
REQ-034 With USR_ROTATE_EN defined and q=8'h81, start with dir=1, amt=1, rot=1 -> q=8'hC0, sout=1, done pulse.
REQ-035 start with amt=0 -> done high the next cycle, busy never high, q unchanged; load=1 and start=1 together with d=8'h3C -> q=8'h3C and no done pulse.
REQ-036 Drive rst_n=0 during the second shift of an amt=5 operation -> q=0 and busy=0 immediately; after release, a load of 8'hFF succeeds on the next edge.
